// File: rtl/hazard_if.sv
// Purpose : bundles the ID-stage hazard-check inputs and the stall/forward results.
// Latency : pure wiring, no storage.
// Backpr. : none here; lock_write/pc_hold/ifid_hold carry the stall back to the front end.
// Ports   : id_* describe the instruction in ID (sources, use flags, destination, load flag);
//           lock_write/pc_hold/ifid_hold/fwd_a/fwd_b/stall_cnt are returned by the hazard unit.
//           modport master = decode stage side, modport slave = hazard_stall_unit.
interface hazard_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             id_wreg;
    logic             id_m2reg;
    logic [4:0]       id_rn;

    logic             lock_write;
    logic             pc_hold;
    logic             ifid_hold;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_m2reg, id_rn,
        input  lock_write, pc_hold, ifid_hold, fwd_a, fwd_b, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_m2reg, id_rn,
        output lock_write, pc_hold, ifid_hold, fwd_a, fwd_b, stall_cnt
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Purpose : RAW hazard detection for the ID instruction against EXE/MEM, with stall and forward selects.
// Latency : stall/forward outputs are combinational from shadow regs + ID inputs (same cycle).
// Backpr. : stall raises lock_write, pc_hold and ifid_hold together; the unit itself never waits.
// Ports   : clk, clrn (async active-low), hz (hazard_if.slave): ID instruction info in,
//           lock_write/pc_hold/ifid_hold/fwd_a/fwd_b/stall_cnt out.
// Build   : define HAZARD_FORWARD_EN for the forwarding pipeline (load-use stalls only);
//           without it forward selects are 0 and any EXE/MEM dependency stalls.
module hazard_stall_unit #(
    parameter int CNT_W = 16
) (
    input  logic     clk,
    input  logic     clrn,
    hazard_if.slave  hz
);
    typedef enum logic {RUN, STALL} state_t;

    // Shadow copy of the destination info of the instructions now in EXE and MEM.
    logic             ex_wreg;
    logic [4:0]       ex_rn;
    logic             mem_wreg;
    logic [4:0]       mem_rn;
`ifdef HAZARD_FORWARD_EN
    logic             ex_m2reg;
    logic             mem_m2reg;
`endif

    state_t           state;
    logic [CNT_W-1:0] stall_cnt;

    logic             rs_ex;
    logic             rt_ex;
    logic             rs_mem;
    logic             rt_mem;
    logic             stall;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;

    // Match: stage writes a nonzero register that ID really reads. A bubble in ID reads nothing.
    always_comb begin
        rs_ex  = hz.id_valid & hz.id_use_rs & (hz.id_rs != 5'd0) & ex_wreg  & (ex_rn  == hz.id_rs);
        rt_ex  = hz.id_valid & hz.id_use_rt & (hz.id_rt != 5'd0) & ex_wreg  & (ex_rn  == hz.id_rt);
        rs_mem = hz.id_valid & hz.id_use_rs & (hz.id_rs != 5'd0) & mem_wreg & (mem_rn == hz.id_rs);
        rt_mem = hz.id_valid & hz.id_use_rt & (hz.id_rt != 5'd0) & mem_wreg & (mem_rn == hz.id_rt);
    end

`ifdef HAZARD_FORWARD_EN
    // EXE result wins over MEM; a MEM load forwards its load data rather than the ALU result.
    function automatic logic [1:0] pick_fwd(input logic ex_hit, input logic mem_hit,
                                            input logic mem_load);
        if (ex_hit)
            return 2'd1;
        else if (mem_hit && mem_load)
            return 2'd3;
        else if (mem_hit)
            return 2'd2;
        else
            return 2'd0;
    endfunction

    // Only a load still in EXE cannot be forwarded in time.
    always_comb begin
        stall = (rs_ex | rt_ex) & ex_m2reg;
        fwd_a = 2'd0;
        fwd_b = 2'd0;
        if (!stall) begin
            fwd_a = pick_fwd(rs_ex, rs_mem, mem_m2reg);
            fwd_b = pick_fwd(rt_ex, rt_mem, mem_m2reg);
        end
    end
`else
    // No bypass paths: wait until the producer leaves MEM (WB writes in the first half-cycle).
    always_comb begin
        stall = rs_ex | rt_ex | rs_mem | rt_mem;
        fwd_a = 2'd0;
        fwd_b = 2'd0;
    end
`endif

    // Shadow pipeline. A stall squashes the ID/EXE write, so EXE receives a bubble.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ex_wreg   <= 1'b0;
            ex_rn     <= 5'd0;
            mem_wreg  <= 1'b0;
            mem_rn    <= 5'd0;
`ifdef HAZARD_FORWARD_EN
            ex_m2reg  <= 1'b0;
            mem_m2reg <= 1'b0;
`endif
        end else begin
            mem_wreg  <= ex_wreg;
            mem_rn    <= ex_rn;
`ifdef HAZARD_FORWARD_EN
            mem_m2reg <= ex_m2reg;
`endif
            if (stall) begin
                ex_wreg  <= 1'b0;
`ifdef HAZARD_FORWARD_EN
                ex_m2reg <= 1'b0;
`endif
            end else begin
                ex_wreg  <= hz.id_wreg & hz.id_valid;
                ex_rn    <= hz.id_rn;
`ifdef HAZARD_FORWARD_EN
                ex_m2reg <= hz.id_m2reg & hz.id_valid;
`endif
            end
        end
    end

    // Stall statistics: RUN/STALL tracking plus a saturating count of stalled edges.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= RUN;
            stall_cnt <= '0;
        end else begin
            case (state)
                RUN:     if (stall)  state <= STALL;
                STALL:   if (!stall) state <= RUN;
                default: state <= RUN;
            endcase
            if (stall && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign hz.lock_write = stall;
    assign hz.pc_hold    = stall;
    assign hz.ifid_hold  = stall;
    assign hz.fwd_a      = fwd_a;
    assign hz.fwd_b      = fwd_b;
    assign hz.stall_cnt  = stall_cnt;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Purpose : directed, table-driven check of hazard_stall_unit in whichever build is compiled.
// Latency : one table row per clock; outputs checked on the falling edge of that cycle.
// Backpr. : n/a (bench).
module tb_hazard_stall_unit;
    localparam int CNT_W = 16;

    logic clk;
    logic clrn;

    hazard_if #(.CNT_W(CNT_W)) hz ();

    hazard_stall_unit #(.CNT_W(CNT_W)) dut (
        .clk  (clk),
        .clrn (clrn),
        .hz   (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic       wreg;
        logic       m2reg;
        logic [4:0] rn;
        logic       exp_stall;
        logic [1:0] exp_fa;
        logic [1:0] exp_fb;
        int         exp_cnt;
    } vec_t;

    vec_t vecs[$];
    int checks;
    int errors;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic w, input logic m,
                         input logic [4:0] rn);
        hz.id_valid  = v;
        hz.id_rs     = rs;
        hz.id_rt     = rt;
        hz.id_use_rs = urs;
        hz.id_use_rt = urt;
        hz.id_wreg   = w;
        hz.id_m2reg  = m;
        hz.id_rn     = rn;
    endtask

    task automatic chk_all(input string name, input logic st, input logic [1:0] fa,
                           input logic [1:0] fb, input int cnt);
        chk({name, ".lock_write"}, int'(hz.lock_write), int'(st));
        chk({name, ".pc_hold"},    int'(hz.pc_hold),    int'(st));
        chk({name, ".ifid_hold"},  int'(hz.ifid_hold),  int'(st));
        chk({name, ".fwd_a"},      int'(hz.fwd_a),      int'(fa));
        chk({name, ".fwd_b"},      int'(hz.fwd_b),      int'(fb));
        chk({name, ".stall_cnt"},  int'(hz.stall_cnt),  cnt);
    endtask

    function automatic vec_t mk(input string n, input logic v, input logic [4:0] rs,
                                input logic [4:0] rt, input logic urs, input logic urt,
                                input logic w, input logic m, input logic [4:0] rn,
                                input logic st, input logic [1:0] fa, input logic [1:0] fb,
                                input int cnt);
        vec_t r;
        r.name = n; r.valid = v; r.rs = rs; r.rt = rt; r.use_rs = urs; r.use_rt = urt;
        r.wreg = w; r.m2reg = m; r.rn = rn;
        r.exp_stall = st; r.exp_fa = fa; r.exp_fb = fb; r.exp_cnt = cnt;
        return r;
    endfunction

    initial begin
        checks = 0;
        errors = 0;

`ifdef HAZARD_FORWARD_EN
        //              name          v  rs  rt urs urt w  m  rn   st fa fb cnt
        vecs.push_back(mk("idle",     0, 0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0));
        vecs.push_back(mk("alu_w5",   1, 0,  0, 0, 0, 1, 0, 5,   0, 0, 0, 0));
        vecs.push_back(mk("rd_rs5",   1, 5,  0, 1, 0, 0, 0, 0,   0, 1, 0, 0));
        vecs.push_back(mk("rd_rt5",   1, 0,  5, 0, 1, 0, 0, 0,   0, 0, 2, 0));
        vecs.push_back(mk("ld_w7",    1, 0,  0, 0, 0, 1, 1, 7,   0, 0, 0, 0));
        vecs.push_back(mk("lu_stall", 1, 7,  0, 1, 0, 0, 0, 0,   1, 0, 0, 0));
        vecs.push_back(mk("lu_fwd3",  1, 7,  0, 1, 0, 0, 0, 0,   0, 3, 0, 1));
        vecs.push_back(mk("w_r0",     1, 0,  0, 0, 0, 1, 0, 0,   0, 0, 0, 1));
        vecs.push_back(mk("rd_r0",    1, 0,  0, 1, 1, 0, 0, 0,   0, 0, 0, 1));
        vecs.push_back(mk("w_r4",     1, 0,  0, 0, 0, 1, 0, 4,   0, 0, 0, 1));
        vecs.push_back(mk("rt4_unused", 1, 1, 4, 1, 0, 1, 0, 3,  0, 0, 0, 1));
        vecs.push_back(mk("w_r3_again", 1, 0, 0, 0, 0, 1, 0, 3,  0, 0, 0, 1));
        vecs.push_back(mk("prio_ex",  1, 3,  0, 1, 0, 0, 0, 0,   0, 1, 0, 1));
        vecs.push_back(mk("inv_w8",   0, 0,  0, 0, 0, 1, 0, 8,   0, 0, 0, 1));
        vecs.push_back(mk("rd_r8",    1, 8,  0, 1, 0, 0, 0, 0,   0, 0, 0, 1));
        vecs.push_back(mk("ld_w6",    1, 0,  0, 0, 0, 1, 1, 6,   0, 0, 0, 1));
        vecs.push_back(mk("inv_rd6",  0, 6,  0, 1, 0, 0, 0, 0,   0, 0, 0, 1));
        vecs.push_back(mk("rd6_mem",  1, 6,  0, 1, 0, 0, 0, 0,   0, 3, 0, 1));
`else
        vecs.push_back(mk("idle",     0, 0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0));
        vecs.push_back(mk("alu_w9",   1, 0,  0, 0, 0, 1, 0, 9,   0, 0, 0, 0));
        vecs.push_back(mk("rd9_ex",   1, 9,  0, 1, 0, 0, 0, 0,   1, 0, 0, 0));
        vecs.push_back(mk("rd9_mem",  1, 9,  0, 1, 0, 0, 0, 0,   1, 0, 0, 1));
        vecs.push_back(mk("rd9_go",   1, 9,  0, 1, 0, 0, 0, 0,   0, 0, 0, 2));
        vecs.push_back(mk("w_r0",     1, 0,  0, 0, 0, 1, 0, 0,   0, 0, 0, 2));
        vecs.push_back(mk("rd_r0",    1, 0,  0, 1, 1, 0, 0, 0,   0, 0, 0, 2));
        vecs.push_back(mk("w_r4",     1, 0,  0, 0, 0, 1, 0, 4,   0, 0, 0, 2));
        vecs.push_back(mk("rt4_unused", 1, 1, 4, 1, 0, 0, 0, 0,  0, 0, 0, 2));
        vecs.push_back(mk("w_r3",     1, 0,  0, 0, 0, 1, 0, 3,   0, 0, 0, 2));
        vecs.push_back(mk("nop",      1, 0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 2));
        vecs.push_back(mk("rt3_mem",  1, 0,  3, 0, 1, 0, 0, 0,   1, 0, 0, 2));
        vecs.push_back(mk("rt3_go",   1, 0,  3, 0, 1, 0, 0, 0,   0, 0, 0, 3));
        vecs.push_back(mk("inv_w8",   0, 0,  0, 0, 0, 1, 0, 8,   0, 0, 0, 3));
        vecs.push_back(mk("rd_r8",    1, 8,  0, 1, 0, 0, 0, 0,   0, 0, 0, 3));
`endif

        // Reset state, checked while clrn is still low.
        clrn = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 0);
        clrn = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].valid, vecs[i].rs, vecs[i].rt, vecs[i].use_rs, vecs[i].use_rt,
                  vecs[i].wreg, vecs[i].m2reg, vecs[i].rn);
            @(negedge clk);
            chk_all(vecs[i].name, vecs[i].exp_stall, vecs[i].exp_fa, vecs[i].exp_fb,
                    vecs[i].exp_cnt);
            @(posedge clk);
            #1;
        end

        // Reset mid-stall: a load to r2 followed by its consumer stalls in both builds.
        drive(1, 0, 0, 0, 0, 1, 1, 2);
        @(posedge clk);
        #1;
        drive(1, 2, 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("mid_stall.lock_write", int'(hz.lock_write), 1);
        #1;
        clrn = 1'b0;
        #1;
        chk_all("rst_mid_stall", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        clrn = 1'b1;
        @(negedge clk);
        chk_all("after_rst", 0, 0, 0, 0);
        @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net against a stuck run.
    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Producer side of the ID/EXE stall interface. Detects read-after-write hazards between the instruction in ID and the instructions in flight in EXE and MEM.
- Drives lock_write (bubble insert) to the ID/EXE pipeline register, plus hold signals to PC and IF/ID, and ALU operand forwarding selects.
- Keeps its own shadow copy of EXE/MEM destination info, so it needs no taps on downstream registers.

Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter

Ports:
- clk  in  1  rising-edge clock
- clrn  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction (0 = bubble)
- id_rs  in  5  source register A of ID instruction
- id_rt  in  5  source register B of ID instruction
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- id_wreg  in  1  ID instruction writes register file
- id_m2reg  in  1  ID instruction is a load
- id_rn  in  5  ID destination register
- lock_write  out  1  to ID/EXE register: squash write enables this cycle
- pc_hold  out  1  hold PC
- ifid_hold  out  1  hold IF/ID register
- fwd_a  out  2  operand A select: 0 regfile, 1 EXE ALU result, 2 MEM ALU result, 3 MEM load data
- fwd_b  out  2  operand B select, same encoding
- stall_cnt  out  CNT_W  total stall cycles since reset, saturating

Behaviour:
- Shadow registers: ex_wreg, ex_m2reg, ex_rn, mem_wreg, mem_m2reg, mem_rn.
- Reset (clrn=0, async): all shadows 0, stall_cnt 0, state RUN.
- Outputs are combinational from the shadows and ID inputs. After reset: lock_write=0, pc_hold=0, ifid_hold=0, fwd_a=0, fwd_b=0.
- Each posedge:
  - mem_* <= ex_*.
  - If stall=1: ex_wreg <= 0 and ex_m2reg <= 0 (bubble, mirrors ID/EXE squash). ex_rn is don't-care.
  - Otherwise: ex_wreg <= id_wreg & id_valid, ex_m2reg <= id_m2reg & id_valid, ex_rn <= id_rn.
- Match rule for source s, stage X: X_wreg=1, X_rn==s, s!=0, and the matching id_use_* is 1. Register 0 never matches.
- Stall (forwarding build): stall=1 iff rs or rt matches EXE and ex_m2reg=1 (load-use).
- Forward priority, per operand:
  - EXE match with ex_m2reg=0 -> 1
  - else MEM match with mem_m2reg=1 -> 3
  - else MEM match -> 2
  - else 0
  - EXE always beats MEM.
- Forward selects are forced to 0 while stall=1.
- lock_write = pc_hold = ifid_hold = stall.
- State machine (stall statistics only):
  - RUN -> STALL when stall=1 at a clock edge.
  - STALL -> RUN when stall=0.
  - stall_cnt increments on every edge with stall=1 and saturates at all ones (no wrap).
- A load-use hazard stalls exactly 1 cycle. The bubble clears ex_wreg, the load moves to MEM, and the selects then give 3.
- id_valid=0 never causes a stall and inserts nothing into the shadow.
- Reset asserted mid-stall: stall drops immediately (combinational from cleared shadows), counter clears.

Optional Feature:
- Macro: HAZARD_FORWARD_EN.
- Defined: behaviour as above.
- Undefined:
  - fwd_a and fwd_b are tied to 0.
  - stall=1 iff either source matches EXE or MEM, regardless of m2reg.
  - Register file writes in WB first half, so no WB check is needed.
  - Dependent on EXE: 2 stall cycles. Dependent on MEM: 1 stall cycle.

Test Plan:
- Reset pulse mid-stall -> all outputs 0 immediately, stall_cnt=0, next instruction unstalled.
- Forwarding build, ALU producer then consumer:
  - Stimulus: id_wreg=1, id_rn=5, m2reg=0; next cycle id_rs=5, use_rs=1.
  - Required: fwd_a=1, lock_write=0.
  - One cycle later, a consumer with rt=5 -> fwd_b=2.
- Forwarding build, load-use:
  - Stimulus: load to r7, then rs=7.
  - Required: lock_write=1 for exactly 1 cycle, fwd_a=0 during the stall, then fwd_a=3; stall_cnt=1.
- Register 0 and unused sources:
  - Stimulus: writer to r0 followed by reader of r0; and a writer to r4 followed by an instruction with rt=4 but use_rt=0.
  - Required: no stall, fwd=0.
- Priority:
  - Stimulus: r3 written by both EXE (ALU) and MEM instructions, ID reads r3.
  - Required: fwd_a=1.
- HAZARD_FORWARD_EN undefined:
  - Stimulus: ALU write r9 immediately followed by reader of r9.
  - Required: lock_write high 2 cycles, fwd always 0, stall_cnt=2.
